// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the memory-stage responder and the memory slave.
// One req/ack transaction at a time; read data is valid in the ack cycle.
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    output bus_be,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    input  bus_be,
    output bus_ack,
    output bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage responder: takes a load/store request from the control FSM,
// runs one bus transaction and reports completion (mem_done) or an error
// (mem_err) with a single-cycle pulse. Load results are aligned and extended.
module mem_access_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      MEM_en,
  input  logic                      L_or_S,
  input  logic [2:0]                funct3,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  output logic [31:0]               rdata,
  output logic                      mem_done,
  output logic                      mem_err,
  mem_access_unit_if.master         bus
);

  // Counter wide enough to hold TIMEOUT itself.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] counter_reg;
  logic          is_store_reg;
  logic [2:0]    funct3_reg;
  logic [1:0]    addr_lo_reg;

  logic          access_ok;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;
  logic [31:0]   load_sel;
  logic [31:0]   load_value;

  // Decode the incoming request: legality, byte enables and lane-replicated data.
  always_comb begin
    access_ok  = 1'b1;
    lane_be    = 4'b1111;
    lane_wdata = 32'd0;

    case (funct3)
      3'b000, 3'b100: access_ok = 1'b1;
      3'b001, 3'b101: access_ok = ~addr[0];
      3'b010:         access_ok = (addr[1:0] == 2'b00);
      default:        access_ok = 1'b0;
    endcase
    // Unsigned variants only exist for loads.
    if (L_or_S && funct3[2]) begin
      access_ok = 1'b0;
    end

    if (L_or_S) begin
      case (funct3[1:0])
        2'b00: begin
          lane_be    = 4'b0001 << addr[1:0];
          lane_wdata = {4{wdata[7:0]}};
        end
        2'b01: begin
          lane_be    = addr[1] ? 4'b1100 : 4'b0011;
          lane_wdata = {2{wdata[15:0]}};
        end
        default: begin
          lane_be    = 4'b1111;
          lane_wdata = wdata;
        end
      endcase
    end
  end

  // Shift the addressed byte/half down to bit 0 and extend it per the load type.
  always_comb begin
    load_sel   = bus.bus_rdata >> {addr_lo_reg, 3'b000};
    load_value = bus.bus_rdata;
    case (funct3_reg)
      3'b000:  load_value = {{24{load_sel[7]}}, load_sel[7:0]};
      3'b001:  load_value = {{16{load_sel[15]}}, load_sel[15:0]};
      3'b100:  load_value = {24'd0, load_sel[7:0]};
      3'b101:  load_value = {16'd0, load_sel[15:0]};
      default: load_value = bus.bus_rdata;
    endcase
  end

  // Control FSM with all outputs registered; reset abandons any transaction silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      counter_reg   <= '0;
      is_store_reg  <= 1'b0;
      funct3_reg    <= 3'd0;
      addr_lo_reg   <= 2'd0;
      rdata         <= 32'd0;
      mem_done      <= 1'b0;
      mem_err       <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'd0;
      bus.bus_wdata <= 32'd0;
      bus.bus_be    <= 4'd0;
    end else begin
      mem_done <= 1'b0;
      mem_err  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (MEM_en) begin
            is_store_reg <= L_or_S;
            funct3_reg   <= funct3;
            addr_lo_reg  <= addr[1:0];
            if (!access_ok) begin
              // Illegal access never touches the bus.
              state_reg <= ERR;
              mem_done  <= 1'b1;
              mem_err   <= 1'b1;
            end else begin
              state_reg     <= REQ;
              counter_reg   <= CW'(1);
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= L_or_S;
              bus.bus_addr  <= {addr[31:2], 2'b00};
              bus.bus_wdata <= lane_wdata;
              bus.bus_be    <= lane_be;
            end
          end
        end

        REQ: begin
          // An ack in the final allowed cycle still completes normally.
          if (bus.bus_ack) begin
            state_reg   <= DONE;
            bus.bus_req <= 1'b0;
            mem_done    <= 1'b1;
            if (!is_store_reg) begin
              rdata <= load_value;
            end
          end else if (counter_reg == CW'(TIMEOUT)) begin
            state_reg   <= ERR;
            bus.bus_req <= 1'b0;
            mem_done    <= 1'b1;
            mem_err     <= 1'b1;
          end else begin
            counter_reg <= counter_reg + CW'(1);
          end
        end

        DONE: state_reg <= IDLE;

        ERR:  state_reg <= IDLE;

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, alignment errors,
// timeout behaviour and reset abandonment, with hand-computed expectations.
module tb_mem_access_unit;
  localparam int TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic        MEM_en;
  logic        L_or_S;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mem_done;
  logic        mem_err;

  int checks_total;
  int checks_passed;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .MEM_en   (MEM_en),
    .L_or_S   (L_or_S),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .mem_done (mem_done),
    .mem_err  (mem_err),
    .bus      (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns in cycle N+1 (after the sampling edge).
  task automatic issue(input logic ls, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    MEM_en = 1'b1;
    L_or_S = ls;
    funct3 = f3;
    addr   = a;
    wdata  = wd;
    @(negedge clk);
    MEM_en = 1'b0;
  endtask

  // Load acked on the first REQ cycle; checks bus request, latency and result.
  task automatic run_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rd, input logic [31:0] exp);
    issue(1'b0, f3, a, 32'd0);
    check({name, " req"}, 32'(bus_if.bus_req), 32'd1);
    check({name, " addr"}, bus_if.bus_addr, {a[31:2], 2'b00});
    check({name, " be"}, 32'(bus_if.bus_be), 32'hF);
    check({name, " we"}, 32'(bus_if.bus_we), 32'd0);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = rd;
    @(negedge clk);
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h5A5A5A5A;
    check({name, " done"}, 32'(mem_done), 32'd1);
    check({name, " err"}, 32'(mem_err), 32'd0);
    check({name, " rdata"}, rdata, exp);
    check({name, " req drop"}, 32'(bus_if.bus_req), 32'd0);
    @(negedge clk);
    check({name, " done pulse"}, 32'(mem_done), 32'd0);
    $display("txn %s addr=0x%08h rdata=0x%08h", name, a, rdata);
  endtask

  // Request rejected in IDLE: error pulse in N+1 and the bus never asserted.
  task automatic run_err(input string name, input logic ls, input logic [2:0] f3,
                         input logic [31:0] a);
    logic [31:0] rd_before;
    rd_before = rdata;
    issue(ls, f3, a, 32'h11223344);
    check({name, " req"}, 32'(bus_if.bus_req), 32'd0);
    check({name, " done"}, 32'(mem_done), 32'd1);
    check({name, " err"}, 32'(mem_err), 32'd1);
    check({name, " rdata"}, rdata, rd_before);
    @(negedge clk);
    check({name, " done pulse"}, 32'(mem_done), 32'd0);
    check({name, " err pulse"}, 32'(mem_err), 32'd0);
    check({name, " req after"}, 32'(bus_if.bus_req), 32'd0);
    $display("txn %s addr=0x%08h error", name, a);
  endtask

  // Store acked after ack_cycle REQ cycles; bus fields must hold steady throughout.
  task automatic run_store(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int ack_cycle,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd);
    logic [31:0] rd_before;
    rd_before = rdata;
    issue(1'b1, f3, a, wd);
    for (int c = 1; c <= ack_cycle; c++) begin
      check({name, " req"}, 32'(bus_if.bus_req), 32'd1);
      check({name, " we"}, 32'(bus_if.bus_we), 32'd1);
      check({name, " addr"}, bus_if.bus_addr, {a[31:2], 2'b00});
      check({name, " be"}, 32'(bus_if.bus_be), 32'(exp_be));
      check({name, " wdata"}, bus_if.bus_wdata, exp_wd);
      check({name, " no done"}, 32'(mem_done), 32'd0);
      if (c == ack_cycle) begin
        MEM_en           = 1'b0;
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'hCAFEF00D;
      end else begin
        // A request arriving mid-transaction must not disturb it.
        MEM_en = 1'b1;
        L_or_S = 1'b0;
        funct3 = 3'b010;
        addr   = 32'h00000900;
      end
      @(negedge clk);
    end
    bus_if.bus_ack = 1'b0;
    check({name, " done"}, 32'(mem_done), 32'd1);
    check({name, " err"}, 32'(mem_err), 32'd0);
    check({name, " rdata kept"}, rdata, rd_before);
    @(negedge clk);
    check({name, " done pulse"}, 32'(mem_done), 32'd0);
    check({name, " idle req"}, 32'(bus_if.bus_req), 32'd0);
    $display("txn %s addr=0x%08h be=%b wdata=0x%08h", name, a, exp_be, exp_wd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          req_cycles;
    logic [31:0] rd_before;

    checks_total     = 0;
    checks_passed    = 0;
    rst              = 1'b1;
    MEM_en           = 1'b0;
    L_or_S           = 1'b0;
    funct3           = 3'd0;
    addr             = 32'd0;
    wdata            = 32'd0;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'd0;

    repeat (2) @(negedge clk);
    check("rst rdata", rdata, 32'd0);
    check("rst done", 32'(mem_done), 32'd0);
    check("rst err", 32'(mem_err), 32'd0);
    check("rst req", 32'(bus_if.bus_req), 32'd0);
    check("rst we", 32'(bus_if.bus_we), 32'd0);
    check("rst addr", bus_if.bus_addr, 32'd0);
    check("rst wdata", bus_if.bus_wdata, 32'd0);
    check("rst be", 32'(bus_if.bus_be), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Ack while idle is ignored.
    bus_if.bus_ack = 1'b1;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    check("idle ack done", 32'(mem_done), 32'd0);
    check("idle ack req", 32'(bus_if.bus_req), 32'd0);

    run_load("LW",  3'b010, 32'h00000100, 32'hDEADBEEF, 32'hDEADBEEF);
    run_load("LB",  3'b000, 32'h00000103, 32'h80123456, 32'hFFFFFF80);
    run_load("LBU", 3'b100, 32'h00000103, 32'h80123456, 32'h00000080);
    run_load("LB1", 3'b000, 32'h00000101, 32'h80123456, 32'h00000034);
    run_load("LH",  3'b001, 32'h00000102, 32'h80123456, 32'hFFFF8012);
    run_load("LHU", 3'b101, 32'h00000102, 32'h80123456, 32'h00008012);
    run_load("LH0", 3'b001, 32'h00000100, 32'h80129876, 32'hFFFF9876);

    run_store("SH", 3'b001, 32'h00000202, 32'h0000ABCD, 3, 4'b1100, 32'hABCDABCD);
    run_store("SB", 3'b000, 32'h00000103, 32'h12345678, 1, 4'b1000, 32'h78787878);
    run_store("SW", 3'b010, 32'h00000204, 32'h12345678, 2, 4'b1111, 32'h12345678);

    run_err("LW mis",   1'b0, 3'b010, 32'h00000101);
    run_err("f3 011",   1'b0, 3'b011, 32'h00000100);
    run_err("LH mis",   1'b0, 3'b001, 32'h00000103);
    run_err("SBU",      1'b1, 3'b100, 32'h00000100);

    // No ack: bus_req for exactly TIMEOUT cycles, then an error pulse.
    rd_before = rdata;
    issue(1'b0, 3'b010, 32'h00000300, 32'd0);
    req_cycles = 0;
    while (bus_if.bus_req && req_cycles < 4 * TIMEOUT) begin
      req_cycles++;
      @(negedge clk);
    end
    check("timeout cycles", 32'(req_cycles), 32'(TIMEOUT));
    check("timeout done", 32'(mem_done), 32'd1);
    check("timeout err", 32'(mem_err), 32'd1);
    check("timeout rdata", rdata, rd_before);
    @(negedge clk);
    check("timeout pulse", 32'(mem_done), 32'd0);
    $display("txn timeout req_cycles=%0d", req_cycles);

    // Ack exactly in the last allowed cycle completes without error.
    issue(1'b0, 3'b010, 32'h00000304, 32'd0);
    repeat (TIMEOUT - 1) @(negedge clk);
    check("late ack req", 32'(bus_if.bus_req), 32'd1);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h0BADF00D;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    check("late ack done", 32'(mem_done), 32'd1);
    check("late ack err", 32'(mem_err), 32'd0);
    check("late ack rdata", rdata, 32'h0BADF00D);
    @(negedge clk);
    $display("txn late-ack rdata=0x%08h", rdata);

    // Reset during REQ abandons the transaction; a coincident MEM_en is ignored.
    issue(1'b0, 3'b010, 32'h00000400, 32'd0);
    check("rst-req req", 32'(bus_if.bus_req), 32'd1);
    rst    = 1'b1;
    MEM_en = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    MEM_en = 1'b0;
    check("rst-req drop", 32'(bus_if.bus_req), 32'd0);
    check("rst-req done", 32'(mem_done), 32'd0);
    check("rst-req rdata", rdata, 32'd0);
    @(negedge clk);
    check("rst-req idle req", 32'(bus_if.bus_req), 32'd0);
    check("rst-req idle done", 32'(mem_done), 32'd0);
    $display("txn reset-in-req");

    // Unit is usable again after the abandoned transaction.
    run_load("LW post", 3'b010, 32'h00000500, 32'h13579BDF, 32'h13579BDF);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
